// File: rtl/preescalador_pkg.sv
// Shared definitions for the programmable prescaler: mode encodings, default
// divisor and the channel-select width helper.
package preescalador_pkg;

    localparam logic MODO_PULSO    = 1'b0;
    localparam logic MODO_CUADRADA = 1'b1;

    localparam int LIM_DEF = 100000;

    // A single channel still needs a one-bit select so the port never collapses.
    function automatic int sel_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/preescalador_if.sv
// Control/status bundle of the prescaler. master drives the controls and
// reads the ticks; slave is the prescaler side.
interface preescalador_if
    import preescalador_pkg::*;
#(
    parameter int N_CH = 3,
    parameter int W    = 17,
    parameter int SELW = sel_w(N_CH)
);
    // i_Wr is a one-cycle strobe with no back-pressure; o_Err answers a
    // rejected strobe exactly one cycle later.
    logic [N_CH-1:0] i_En;
    logic            i_Clr;
    logic            i_Wr;
    logic [SELW-1:0] i_Sel;
    logic [W-1:0]    i_Lim;
    logic [N_CH-1:0] i_Mode;
    logic [N_CH-1:0] o_Tick;
    logic [N_CH-1:0] o_Sq;
    logic            o_Err;

    modport master (
        output i_En, i_Clr, i_Wr, i_Sel, i_Lim, i_Mode,
        input  o_Tick, o_Sq, o_Err
    );

    modport slave (
        input  i_En, i_Clr, i_Wr, i_Sel, i_Lim, i_Mode,
        output o_Tick, o_Sq, o_Err
    );
endinterface

// File: rtl/preescalador_canal.sv
// One prescaler channel: wrap counter, double-buffered divisor, registered
// tick and optional square wave.
module preescalador_canal
    import preescalador_pkg::*;
#(
    parameter int W    = 17,
    parameter int LIM0 = LIM_DEF
) (
    input  logic         i_Clk,
    input  logic         i_Reset,
    input  logic         i_En,
    input  logic         i_Clr,
    input  logic         i_Wr,
    input  logic         i_Mode,
    input  logic [W-1:0] i_Lim,
    output logic         o_Tick,
    output logic         o_Sq
);
    localparam logic [W-1:0] LIM0_W = W'(LIM0);

    logic [W-1:0] r_cta;
    logic [W-1:0] r_lim_act;
    logic [W-1:0] r_lim_shd;
    logic         r_tick;
    logic         r_sq;

    logic w_wrap;
    logic w_sq_run;

    // >= rather than == so a shrunken divisor below the count still wraps.
    assign w_wrap   = (r_cta >= (r_lim_act - W'(1)));
    assign w_sq_run = (i_Mode == MODO_CUADRADA) ? r_sq : 1'b0;

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            r_cta     <= '0;
            r_lim_act <= LIM0_W;
            r_lim_shd <= LIM0_W;
            r_tick    <= 1'b0;
            r_sq      <= 1'b0;
        end else begin
            if (i_Clr) begin
                r_cta     <= '0;
                r_tick    <= 1'b0;
                r_sq      <= 1'b0;
                r_lim_act <= r_lim_shd;
            end else if (i_En) begin
                if (w_wrap) begin
                    r_cta     <= '0;
                    r_tick    <= 1'b1;
                    r_sq      <= (i_Mode == MODO_CUADRADA) ? ~r_sq : 1'b0;
                    // A write landing on the wrap edge governs the very next period.
                    r_lim_act <= i_Wr ? i_Lim : r_lim_shd;
                end else begin
                    r_cta  <= r_cta + W'(1);
                    r_tick <= 1'b0;
                    r_sq   <= w_sq_run;
                end
            end else begin
                r_tick    <= 1'b0;
                r_sq      <= w_sq_run;
                r_lim_act <= r_lim_shd;
            end
            if (i_Wr) begin
                r_lim_shd <= i_Lim;
            end
        end
    end

    assign o_Tick = r_tick;
    assign o_Sq   = r_sq;

endmodule

// File: rtl/preescalador_prog.sv
// Multi-channel programmable prescaler: write decode, error pulse and N_CH
// independent channels.
module preescalador_prog
    import preescalador_pkg::*;
#(
    parameter int N_CH = 3,
    parameter int W    = 17,
    parameter int LIM0 = LIM_DEF
) (
    input  logic           i_Clk,
    input  logic           i_Reset,
    preescalador_if.slave  bus
);
    localparam int SELW = sel_w(N_CH);

    if ((LIM0 < 1) || (longint'(LIM0) >= (longint'(1) << W))) begin : g_lim0_range
        $error("LIM0 must be in 1 .. 2**W-1");
    end

    logic            w_sel_ok;
    logic            w_acc;
    logic [N_CH-1:0] w_tick;
    logic [N_CH-1:0] w_sq;
    logic            r_err;

    assign w_sel_ok = (32'(bus.i_Sel) < 32'(N_CH));
    assign w_acc    = bus.i_Wr & w_sel_ok & (bus.i_Lim != '0);

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= bus.i_Wr & ~w_acc;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_canal
        logic w_wr_ch;
        assign w_wr_ch = w_acc & (bus.i_Sel == SELW'(c));

        preescalador_canal #(
            .W    (W),
            .LIM0 (LIM0)
        ) u_canal (
            .i_Clk   (i_Clk),
            .i_Reset (i_Reset),
            .i_En    (bus.i_En[c]),
            .i_Clr   (bus.i_Clr),
            .i_Wr    (w_wr_ch),
            .i_Mode  (bus.i_Mode[c]),
            .i_Lim   (bus.i_Lim),
            .o_Tick  (w_tick[c]),
            .o_Sq    (w_sq[c])
        );
    end

    assign bus.o_Tick = w_tick;
    assign bus.o_Sq   = w_sq;
    assign bus.o_Err  = r_err;

endmodule

// File: tb/tb_preescalador_prog.sv
// Bench for preescalador_prog (N_CH=3, W=8, LIM0=5): directed steps followed by
// random traffic, all checked cycle by cycle against a behavioural model.
module tb_preescalador_prog;
    import preescalador_pkg::*;

    localparam int NC   = 3;
    localparam int WW   = 8;
    localparam int L0   = 5;
    localparam int GUARD = 60;

    logic clk;
    logic rst_n;

    preescalador_if #(.N_CH(NC), .W(WW)) bus ();

    preescalador_prog #(.N_CH(NC), .W(WW), .LIM0(L0)) dut (
        .i_Clk   (clk),
        .i_Reset (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: cycles elapsed in the current period, active/pending divisors.
    int m_cnt [NC];
    int m_act [NC];
    int m_shd [NC];
    bit m_sq  [NC];
    bit m_tick[NC];
    bit m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_cnt[c] = 0; m_act[c] = L0; m_shd[c] = L0;
            m_sq[c] = 1'b0; m_tick[c] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    task automatic model_step();
        bit acc;
        bit hit;
        int lim;
        lim = int'(bus.i_Lim);
        acc = bus.i_Wr && (int'(bus.i_Sel) < NC) && (lim != 0);
        m_err = bus.i_Wr && !acc;
        for (int c = 0; c < NC; c++) begin
            hit = acc && (int'(bus.i_Sel) == c);
            if (bus.i_Clr) begin
                m_cnt[c] = 0; m_tick[c] = 1'b0; m_sq[c] = 1'b0;
                m_act[c] = m_shd[c];
            end else if (bus.i_En[c]) begin
                if (m_cnt[c] + 1 >= m_act[c]) begin
                    m_cnt[c] = 0; m_tick[c] = 1'b1;
                    m_sq[c] = bus.i_Mode[c] ? !m_sq[c] : 1'b0;
                    m_act[c] = hit ? lim : m_shd[c];
                end else begin
                    m_cnt[c]++; m_tick[c] = 1'b0;
                    if (!bus.i_Mode[c]) m_sq[c] = 1'b0;
                end
            end else begin
                m_tick[c] = 1'b0;
                if (!bus.i_Mode[c]) m_sq[c] = 1'b0;
                m_act[c] = m_shd[c];
            end
            if (hit) m_shd[c] = lim;
        end
    endtask

    task automatic compare_all(input string tag);
        logic [NC-1:0] et;
        logic [NC-1:0] es;
        for (int c = 0; c < NC; c++) begin
            et[c] = m_tick[c];
            es[c] = m_sq[c];
        end
        check({tag, ".tick"}, 32'(bus.o_Tick), 32'(et));
        check({tag, ".sq"},   32'(bus.o_Sq),   32'(es));
        check({tag, ".err"},  32'(bus.o_Err),  32'(m_err));
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic idle_inputs();
        bus.i_Wr = 1'b0; bus.i_Clr = 1'b0; bus.i_Sel = '0; bus.i_Lim = '0;
    endtask

    initial begin
        int g;
        rst_n = 1'b0;
        bus.i_En = '0; bus.i_Mode = '0;
        idle_inputs();
        model_reset();
        #2;
        compare_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // All channels pulse-only: ticks every 5 edges.
        bus.i_En = 3'b111;
        for (int i = 0; i < 15; i++) step("pulse");

        // Channel 1 square wave.
        bus.i_Mode = 3'b010;
        for (int i = 0; i < 20; i++) step("square");

        // Divisor write mid-period on channel 0 (count 2).
        for (int i = 0; i < 2; i++) step("pre_wr");
        check("cta0_is_2", 32'(m_cnt[0]), 32'd2);
        bus.i_Wr = 1'b1; bus.i_Sel = 2'd0; bus.i_Lim = 8'd3;
        step("wr_mid");
        idle_inputs();
        for (int i = 0; i < 12; i++) step("after_wr");

        // Write landing exactly on a channel-2 wrap edge.
        g = 0;
        while ((m_cnt[2] + 1 < m_act[2]) && g < GUARD) begin step("seek2"); g++; end
        check("seek2_bound", 32'(g < GUARD), 32'd1);
        bus.i_Wr = 1'b1; bus.i_Sel = 2'd2; bus.i_Lim = 8'd2;
        step("wr_bypass");
        idle_inputs();
        for (int i = 0; i < 6; i++) step("after_bypass");

        // Rejected writes.
        bus.i_Wr = 1'b1; bus.i_Sel = 2'd3; bus.i_Lim = 8'd7;
        step("bad_sel");
        bus.i_Sel = 2'd1; bus.i_Lim = 8'd0;
        step("bad_lim");
        idle_inputs();
        for (int i = 0; i < 10; i++) step("after_err");

        // Channel 0 back to 5, then disabled for 7 edges at count 3.
        bus.i_Wr = 1'b1; bus.i_Sel = 2'd0; bus.i_Lim = 8'd5;
        step("wr_ch0");
        idle_inputs();
        g = 0;
        while (m_cnt[0] != 3 && g < GUARD) begin step("seek0"); g++; end
        check("seek0_bound", 32'(g < GUARD), 32'd1);
        bus.i_En = 3'b110;
        for (int i = 0; i < 7; i++) step("dis0");
        bus.i_En = 3'b111;
        for (int i = 0; i < 6; i++) step("reen0");

        // Clear on a channel-1 wrap edge.
        g = 0;
        while ((m_cnt[1] + 1 < m_act[1]) && g < GUARD) begin step("seek1"); g++; end
        check("seek1_bound", 32'(g < GUARD), 32'd1);
        bus.i_Clr = 1'b1;
        step("clr");
        bus.i_Clr = 1'b0;
        for (int i = 0; i < 8; i++) step("after_clr");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < NC; c++) bus.i_En[c] = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 19) == 0) bus.i_Mode = NC'($urandom_range(0, 7));
            bus.i_Wr  = ($urandom_range(0, 9) == 0);
            bus.i_Sel = 2'($urandom_range(0, 3));
            bus.i_Lim = 8'($urandom_range(0, 9));
            bus.i_Clr = ($urandom_range(0, 49) == 0);
            step("rand");
        end
        idle_inputs();
        bus.i_En = 3'b111;

        // Asynchronous reset while a tick is being shown.
        g = 0;
        while (!m_tick[0] && g < GUARD) begin step("seek_tick"); g++; end
        check("seek_tick_bound", 32'(g < GUARD), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) step("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
